// File: rtl/turn_countdown_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// turn_timer_pkg
// Shared definitions for the two-player turn countdown path.
//   state_t        : controller states (IDLE, RUN, EXPIRED)
//   DIGIT_W        : width of one BCD digit
//   DEFAULT_CLK_HZ : default system clock frequency
//   reload_*()     : M:SS reload digits derived from a seconds budget;
//                    evaluated at elaboration only
// -----------------------------------------------------------------------------
package turn_timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } state_t;

   localparam int DIGIT_W        = 4;
   localparam int DEFAULT_CLK_HZ = 100_000_000;

   function automatic logic [DIGIT_W-1:0] reload_min(input int secs);
      return DIGIT_W'(secs / 60);
   endfunction

   function automatic logic [DIGIT_W-1:0] reload_tens(input int secs);
      return DIGIT_W'((secs % 60) / 10);
   endfunction

   function automatic logic [DIGIT_W-1:0] reload_ones(input int secs);
      return DIGIT_W'(secs % 10);
   endfunction

endpackage

// File: rtl/turn_countdown_ctrl_if.sv
// -----------------------------------------------------------------------------
// turn_countdown_ctrl_if
// Groups the button input and the display/LED outputs of the turn controller.
//   btnC          : end-turn / start button level (debounced upstream)
//   led[1:0]      : player LEDs, led[0] = player 0 active
//   active_player : current turn owner
//   min_bcd, sec_tens_bcd, sec_ones_bcd : remaining time as M:SS BCD
//   turn_timeout  : one-cycle pulse, turn expired
//   turn_end      : one-cycle pulse, turn ended by button
// Modports: master = button source / display sink, slave = controller.
// -----------------------------------------------------------------------------
interface turn_countdown_ctrl_if;
   import turn_timer_pkg::*;

   logic               btnC;
   logic [1:0]         led;
   logic               active_player;
   logic [DIGIT_W-1:0] min_bcd;
   logic [DIGIT_W-1:0] sec_tens_bcd;
   logic [DIGIT_W-1:0] sec_ones_bcd;
   logic               turn_timeout;
   logic               turn_end;

   modport master (
      output btnC,
      input  led, active_player, min_bcd, sec_tens_bcd, sec_ones_bcd,
             turn_timeout, turn_end
   );

   modport slave (
      input  btnC,
      output led, active_player, min_bcd, sec_tens_bcd, sec_ones_bcd,
             turn_timeout, turn_end
   );

endinterface

// File: rtl/turn_countdown_ctrl_bcd_mmss_down.sv
// -----------------------------------------------------------------------------
// bcd_mmss_down
// Loadable M:SS BCD down-counter.
//   clock, reset : system clock, synchronous active-high reset (loads reload)
//   load         : load the reload value (has priority over dec)
//   dec          : decrement by one second with BCD borrow
//   min_o, tens_o, ones_o : current digits
//   at_one       : count currently reads 0:01
// -----------------------------------------------------------------------------
module bcd_mmss_down
   import turn_timer_pkg::*;
#(
   parameter logic [DIGIT_W-1:0] MIN_R  = 4'd2,
   parameter logic [DIGIT_W-1:0] TENS_R = 4'd0,
   parameter logic [DIGIT_W-1:0] ONES_R = 4'd0
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load,
   input  logic               dec,
   output logic [DIGIT_W-1:0] min_o,
   output logic [DIGIT_W-1:0] tens_o,
   output logic [DIGIT_W-1:0] ones_o,
   output logic               at_one
);

   logic [DIGIT_W-1:0] min_q, min_d;
   logic [DIGIT_W-1:0] tens_q, tens_d;
   logic [DIGIT_W-1:0] ones_q, ones_d;
   logic               zero;

   assign zero = (min_q == '0) && (tens_q == '0) && (ones_q == '0);

   always_comb begin
      min_d  = min_q;
      tens_d = tens_q;
      ones_d = ones_q;
      if (load) begin
         min_d  = MIN_R;
         tens_d = TENS_R;
         ones_d = ONES_R;
      end else if (dec && !zero) begin
         // 0:00 holds so the minutes digit can never wrap.
         if (ones_q != '0) begin
            ones_d = ones_q - 1'b1;
         end else begin
            ones_d = DIGIT_W'(9);
            if (tens_q != '0) begin
               tens_d = tens_q - 1'b1;
            end else begin
               tens_d = DIGIT_W'(5);
               min_d  = min_q - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         min_q  <= MIN_R;
         tens_q <= TENS_R;
         ones_q <= ONES_R;
      end else begin
         min_q  <= min_d;
         tens_q <= tens_d;
         ones_q <= ones_d;
      end
   end

   assign min_o  = min_q;
   assign tens_o = tens_q;
   assign ones_o = ones_q;
   assign at_one = (min_q == '0) && (tens_q == '0) && (ones_q == DIGIT_W'(1));

endmodule

// File: rtl/turn_countdown_ctrl.sv
// -----------------------------------------------------------------------------
// turn_countdown_ctrl
// Two-player turn controller: counts the active player's turn down from
// TURN_SECONDS and hands over on an end-turn press or on timeout.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : btnC in; led, active_player, M:SS BCD digits,
//                  turn_timeout and turn_end pulses out (all registered)
// Parameters: CLK_HZ (one tick every CLK_HZ cycles), TURN_SECONDS (1..599).
// -----------------------------------------------------------------------------
module turn_countdown_ctrl
   import turn_timer_pkg::*;
#(
   parameter int CLK_HZ       = DEFAULT_CLK_HZ,
   parameter int TURN_SECONDS = 120
) (
   input  logic                  clock,
   input  logic                  reset,
   turn_countdown_ctrl_if.slave  bus
);

   localparam int TICK_CYCLES = CLK_HZ;
   localparam int CNT_W       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_CYCLES - 1);
   localparam logic [DIGIT_W-1:0] RL_MIN   = reload_min(TURN_SECONDS);
   localparam logic [DIGIT_W-1:0] RL_TENS  = reload_tens(TURN_SECONDS);
   localparam logic [DIGIT_W-1:0] RL_ONES  = reload_ones(TURN_SECONDS);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             player_q, player_d;
   logic [1:0]       led_q, led_d;
   logic             timeout_q, timeout_d;
   logic             end_q, end_d;
   logic             btn_prev_q;
   logic             btn_edge;
   logic             tick;
   logic             load, dec;
   logic             at_one;

   assign btn_edge = bus.btnC & ~btn_prev_q;
   assign tick     = (state_q == RUN) && (cnt_q == CNT_LAST);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      player_d  = player_q;
      timeout_d = 1'b0;
      end_d     = 1'b0;
      load      = 1'b0;
      dec       = 1'b0;
      unique case (state_q)
         IDLE: begin
            load = 1'b1;
            if (btn_edge) begin
               state_d  = RUN;
               player_d = 1'b0;
               cnt_d    = '0;
            end
         end
         RUN: begin
            // A press beats a coincident tick, so a turn ended at 0:01
            // never shows 0:00 and never raises a timeout.
            if (btn_edge) begin
               player_d = ~player_q;
               load     = 1'b1;
               cnt_d    = '0;
               end_d    = 1'b1;
            end else if (tick) begin
               dec   = 1'b1;
               cnt_d = '0;
               if (at_one) begin
                  state_d   = EXPIRED;
                  timeout_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         EXPIRED: begin
            // Single cycle showing 0:00; any press here is ignored.
            state_d  = RUN;
            player_d = ~player_q;
            load     = 1'b1;
            cnt_d    = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      led_d = (state_d == IDLE) ? 2'b00 : {player_d, ~player_d};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         player_q   <= 1'b0;
         led_q      <= 2'b00;
         timeout_q  <= 1'b0;
         end_q      <= 1'b0;
         btn_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         player_q   <= player_d;
         led_q      <= led_d;
         timeout_q  <= timeout_d;
         end_q      <= end_d;
         btn_prev_q <= bus.btnC;
      end
   end

   logic [DIGIT_W-1:0] min_w, tens_w, ones_w;

   bcd_mmss_down #(
      .MIN_R  (RL_MIN),
      .TENS_R (RL_TENS),
      .ONES_R (RL_ONES)
   ) u_digits (
      .clock  (clock),
      .reset  (reset),
      .load   (load),
      .dec    (dec),
      .min_o  (min_w),
      .tens_o (tens_w),
      .ones_o (ones_w),
      .at_one (at_one)
   );

   assign bus.led           = led_q;
   assign bus.active_player = player_q;
   assign bus.min_bcd       = min_w;
   assign bus.sec_tens_bcd  = tens_w;
   assign bus.sec_ones_bcd  = ones_w;
   assign bus.turn_timeout  = timeout_q;
   assign bus.turn_end      = end_q;

endmodule

// File: tb/tb_turn_countdown_ctrl.sv
// -----------------------------------------------------------------------------
// tb_turn_countdown_ctrl
// Scoreboard bench: the stimulus process queues the expected output snapshot
// for a given cycle; a monitor pops and compares on the falling edge.
// dut1: CLK_HZ=4, TURN_SECONDS=3.  dut2: CLK_HZ=4, TURN_SECONDS=120.
// Snapshot packing: {led[1:0], active_player, M, T, O, turn_timeout, turn_end}
// -----------------------------------------------------------------------------
module tb_turn_countdown_ctrl;
   import turn_timer_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   turn_countdown_ctrl_if bus1 ();
   turn_countdown_ctrl_if bus2 ();

   turn_countdown_ctrl #(.CLK_HZ(4), .TURN_SECONDS(3)) dut1 (
      .clock (clock),
      .reset (reset),
      .bus   (bus1)
   );

   turn_countdown_ctrl #(.CLK_HZ(4), .TURN_SECONDS(120)) dut2 (
      .clock (clock),
      .reset (reset),
      .bus   (bus2)
   );

   typedef struct {
      int          cyc;
      int          dut;
      string       name;
      logic [16:0] exp;
   } ent_t;

   ent_t sb[$];
   int   cyc    = 0;
   int   n_vec  = 0;
   int   n_bad  = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic ex(input int dut, input int c, input string name,
                     input logic [1:0] led, input logic ap,
                     input int m, input int t, input int o,
                     input logic to, input logic te);
      ent_t e;
      e.cyc  = c;
      e.dut  = dut;
      e.name = name;
      e.exp  = {led, ap, 4'(m), 4'(t), 4'(o), to, te};
      sb.push_back(e);
   endtask

   function automatic logic [16:0] snap(input int dut);
      if (dut == 0)
         return {bus1.led, bus1.active_player, bus1.min_bcd, bus1.sec_tens_bcd,
                 bus1.sec_ones_bcd, bus1.turn_timeout, bus1.turn_end};
      else
         return {bus2.led, bus2.active_player, bus2.min_bcd, bus2.sec_tens_bcd,
                 bus2.sec_ones_bcd, bus2.turn_timeout, bus2.turn_end};
   endfunction

   // Monitor: compare every queued snapshot whose cycle has arrived.
   always @(negedge clock) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         ent_t        e;
         logic [16:0] act;
         e   = sb.pop_front();
         act = snap(e.dut);
         n_vec++;
         if (e.cyc != cyc || act !== e.exp) begin
            n_bad++;
            $display("FAIL %s (dut%0d cyc %0d): got %05h, expected %05h at cyc %0d",
                     e.name, e.dut, cyc, act, e.exp, e.cyc);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic goto(input int c);
      while (cyc < c) step();
   endtask

   int M, P;

   initial begin
      bus1.btnC = 1'b0;
      bus2.btnC = 1'b0;
      reset     = 1'b1;
      step();
      step();
      ex(0, cyc, "reset_idle",     2'b00, 1'b0, 0, 0, 3, 1'b0, 1'b0);
      ex(1, cyc, "reset_idle_120", 2'b00, 1'b0, 2, 0, 0, 1'b0, 1'b0);
      reset = 1'b0;
      step();
      step();

      // Start, count down, timeout, ignored press, button swaps, coincident
      // press+tick, reset during EXPIRED with the button held.
      M = cyc;
      bus1.btnC = 1'b1;
      ex(0, M+1,  "start_run",         2'b01, 1'b0, 0, 0, 3, 1'b0, 1'b0);
      ex(0, M+4,  "before_tick1",      2'b01, 1'b0, 0, 0, 3, 1'b0, 1'b0);
      ex(0, M+5,  "tick1_0_02",        2'b01, 1'b0, 0, 0, 2, 1'b0, 1'b0);
      ex(0, M+9,  "tick2_0_01",        2'b01, 1'b0, 0, 0, 1, 1'b0, 1'b0);
      ex(0, M+12, "last_0_01",         2'b01, 1'b0, 0, 0, 1, 1'b0, 1'b0);
      ex(0, M+13, "expired_0_00",      2'b01, 1'b0, 0, 0, 0, 1'b1, 1'b0);
      ex(0, M+14, "after_timeout",     2'b10, 1'b1, 0, 0, 3, 1'b0, 1'b0);
      ex(0, M+15, "expired_press_ign", 2'b10, 1'b1, 0, 0, 3, 1'b0, 1'b0);
      ex(0, M+18, "p1_0_02",           2'b10, 1'b1, 0, 0, 2, 1'b0, 1'b0);
      ex(0, M+20, "btn_end_at_0_02",   2'b01, 1'b0, 0, 0, 3, 1'b0, 1'b1);
      ex(1, M+20, "dut2_still_idle",   2'b00, 1'b0, 2, 0, 0, 1'b0, 1'b0);
      ex(0, M+21, "turn_end_1cyc",     2'b01, 1'b0, 0, 0, 3, 1'b0, 1'b0);
      ex(0, M+23, "restart_no_dec",    2'b01, 1'b0, 0, 0, 3, 1'b0, 1'b0);
      ex(0, M+24, "restart_dec_0_02",  2'b01, 1'b0, 0, 0, 2, 1'b0, 1'b0);
      ex(0, M+28, "p0_0_01",           2'b01, 1'b0, 0, 0, 1, 1'b0, 1'b0);
      ex(0, M+31, "p0_0_01_last",      2'b01, 1'b0, 0, 0, 1, 1'b0, 1'b0);
      ex(0, M+32, "btn_beats_tick",    2'b10, 1'b1, 0, 0, 3, 1'b0, 1'b1);
      ex(0, M+33, "no_timeout_after",  2'b10, 1'b1, 0, 0, 3, 1'b0, 1'b0);
      ex(0, M+43, "p1_0_01_last",      2'b10, 1'b1, 0, 0, 1, 1'b0, 1'b0);
      ex(0, M+44, "expired_p1",        2'b10, 1'b1, 0, 0, 0, 1'b1, 1'b0);
      ex(0, M+45, "reset_in_expired",  2'b00, 1'b0, 0, 0, 3, 1'b0, 1'b0);
      ex(0, M+46, "held_btn_run",      2'b01, 1'b0, 0, 0, 3, 1'b0, 1'b0);
      ex(0, M+47, "held_btn_no_edge",  2'b01, 1'b0, 0, 0, 3, 1'b0, 1'b0);

      goto(M+1);  bus1.btnC = 1'b0;
      goto(M+13); bus1.btnC = 1'b1;
      goto(M+15); bus1.btnC = 1'b0;
      goto(M+19); bus1.btnC = 1'b1;
      goto(M+20); bus1.btnC = 1'b0;
      goto(M+31); bus1.btnC = 1'b1;
      goto(M+32); bus1.btnC = 1'b0;
      goto(M+44); bus1.btnC = 1'b1; reset = 1'b1;
      goto(M+45); reset = 1'b0;
      goto(M+48);

      // Two-digit borrow with a 2:00 budget.
      P = cyc;
      bus2.btnC = 1'b1;
      ex(1, P+1, "b120_start", 2'b01, 1'b0, 2, 0, 0, 1'b0, 1'b0);
      ex(1, P+4, "b120_hold",  2'b01, 1'b0, 2, 0, 0, 1'b0, 1'b0);
      ex(1, P+5, "b120_1_59",  2'b01, 1'b0, 1, 5, 9, 1'b0, 1'b0);
      ex(1, P+8, "b120_hold2", 2'b01, 1'b0, 1, 5, 9, 1'b0, 1'b0);
      ex(1, P+9, "b120_1_58",  2'b01, 1'b0, 1, 5, 8, 1'b0, 1'b0);
      goto(P+1); bus2.btnC = 1'b0;
      goto(P+10);

      for (int i = 0; i < 50 && sb.size() > 0; i++) step();
      if (sb.size() > 0) begin
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
         n_bad += sb.size();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
